// File: rtl/cv32e40p_trace_pkg.sv
// Shared types for the retirement-trace buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Entry layout is {[ts,] wdata, rd, we, instr, pc} with pc in the low 32 bits.
// CV32E40P_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp as the top field.
package cv32e40p_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_e;

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_entry_t;
  localparam int ENTRY_W = 134;
`else
  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_entry_t;
  localparam int ENTRY_W = 102;
`endif

endpackage

// File: rtl/cv32e40p_trace_compact.sv
// Packs eligible channels, lowest index first, into consecutive write slots.
// Latency: purely combinational.
// Backpressure: accepts at most limit_i events; the remainder are reported in rej_cnt_o.
// Ports: ev_elig_i/ev_ent_i per-channel candidates; limit_i slots available;
//        slot_we_o/slot_ent_o slot k lands at wr_ptr+k; acc_cnt_o/rej_cnt_o counts.
module cv32e40p_trace_compact
  import cv32e40p_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0] ev_elig_i,
  input  trace_entry_t      ev_ent_i  [NUM_CH],
  input  logic [CNT_W-1:0]  limit_i,
  output logic [NUM_CH-1:0] slot_we_o,
  output trace_entry_t      slot_ent_o [NUM_CH],
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic [CNT_W-1:0]  rej_cnt_o
);

  int acc;
  int rej;

  always_comb begin
    slot_we_o = '0;
    for (int k = 0; k < NUM_CH; k++) slot_ent_o[k] = '0;
    acc = 0;
    rej = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ev_elig_i[c]) begin
        if (acc < int'(limit_i)) begin
          // constant-index slot select keeps the mux a plain one-hot decode
          for (int k = 0; k < NUM_CH; k++) begin
            if (k == acc) begin
              slot_we_o[k]  = 1'b1;
              slot_ent_o[k] = ev_ent_i[c];
            end
          end
          acc = acc + 1;
        end else begin
          rej = rej + 1;
        end
      end
    end
    acc_cnt_o = CNT_W'(acc);
    rej_cnt_o = CNT_W'(rej);
  end

endmodule

// File: rtl/cv32e40p_trace_buffer.sv
// Multi-channel retirement-trace capture buffer (circular, DEPTH entries) with in-order drain.
// Latency: captured events are visible at out_* one cycle after the retirement strobe.
// Backpressure: out_valid_o/out_ready_i; when full, stop mode drops new events, wrap mode drops oldest.
// Ports: clk_i/rst_i (async, active-high); enable_i, flush_i, trig_en_i, trig_pc_i control;
//        ev_* per-channel retirement taps; out_valid_o/out_ready_i/out_entry_o drain port;
//        level_o occupancy, state_o FSM state, drop_cnt_o saturating lost-event count.
// Build option: CV32E40P_TRACE_TIMESTAMP_EN appends a 32-bit free-running cycle stamp to entries.
module cv32e40p_trace_buffer
  import cv32e40p_trace_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  parameter int WRAP_MODE  = 0,
  parameter int DROP_CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     trig_en_i,
  input  logic [31:0]              trig_pc_i,
  input  logic [NUM_CH-1:0]        ev_valid_i,
  input  logic [NUM_CH*32-1:0]     ev_pc_i,
  input  logic [NUM_CH*32-1:0]     ev_instr_i,
  input  logic [NUM_CH*5-1:0]      ev_rd_i,
  input  logic [NUM_CH-1:0]        ev_we_i,
  input  logic [NUM_CH*32-1:0]     ev_wdata_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ENTRY_W-1:0]       out_entry_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [1:0]               state_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_CH + 1);

  trace_state_e          state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [DROP_CNT_W:0]   drop_sum;
  trace_entry_t          mem_q [DEPTH];

  trace_entry_t          ch_ent   [NUM_CH];
  trace_entry_t          slot_ent [NUM_CH];
  logic [NUM_CH-1:0]     slot_we;
  logic [NUM_CH-1:0]     elig;
  logic [CNT_W-1:0]      limit, acc_cnt, rej_cnt;
  logic                  pop, trig_hit;
  int                    free, ovw, drop_inc;

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_ent[c]       = '0;
      ch_ent[c].pc    = ev_pc_i[c*32 +: 32];
      ch_ent[c].instr = ev_instr_i[c*32 +: 32];
      ch_ent[c].we    = ev_we_i[c];
      ch_ent[c].rd    = ev_rd_i[c*5 +: 5];
      ch_ent[c].wdata = ev_wdata_i[c*32 +: 32];
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
      ch_ent[c].ts    = ts_q;
`endif
    end
  end

  // In ARMED, trig_hit latches on within the channel scan, so only the matching
  // channel and higher-index channels become eligible.
  always_comb begin
    trig_hit = 1'b0;
    elig     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ev_valid_i[c] && (ev_pc_i[c*32 +: 32] == trig_pc_i)) trig_hit = 1'b1;
      case (state_q)
        ST_CAPTURE: elig[c] = ev_valid_i[c];
        ST_ARMED:   elig[c] = ev_valid_i[c] & trig_hit;
        default:    elig[c] = 1'b0;
      endcase
    end
  end

  assign out_valid_o = (level_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_entry_o = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign state_o     = state_q;
  assign drop_cnt_o  = drop_q;

  // A slot being popped this cycle is free for a same-cycle write.
  always_comb begin
    free = DEPTH - int'(level_q) + int'(pop);
    if ((WRAP_MODE != 0) || (free >= NUM_CH)) limit = CNT_W'(NUM_CH);
    else                                      limit = CNT_W'(free);
  end

  cv32e40p_trace_compact #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_compact (
    .ev_elig_i  (elig),
    .ev_ent_i   (ch_ent),
    .limit_i    (limit),
    .slot_we_o  (slot_we),
    .slot_ent_o (slot_ent),
    .acc_cnt_o  (acc_cnt),
    .rej_cnt_o  (rej_cnt)
  );

  always_comb begin
    // wrap mode: every write beyond the free space evicts the current oldest entry
    ovw = ((WRAP_MODE != 0) && (int'(acc_cnt) > free)) ? (int'(acc_cnt) - free) : 0;
    if (WRAP_MODE != 0)            drop_inc = ovw;
    else if (state_q == ST_FROZEN) drop_inc = $countones(ev_valid_i);
    else                           drop_inc = int'(rej_cnt);

    drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(drop_inc);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    level_d  = LVL_W'(int'(level_q) + int'(acc_cnt) - int'(pop) - ovw);
    wr_ptr_d = wr_ptr_q + PTR_W'(acc_cnt);
    rd_ptr_d = rd_ptr_q + PTR_W'(int'(pop) + ovw);
    if (flush_i) begin
      drop_d   = '0;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable_i) state_d = trig_en_i ? ST_ARMED : ST_CAPTURE;
      ST_ARMED:   if (trig_hit) state_d = ST_CAPTURE;
      ST_CAPTURE: if ((WRAP_MODE == 0) && (int'(level_d) == DEPTH)) state_d = ST_FROZEN;
      ST_FROZEN:  if (int'(level_d) < DEPTH) state_d = ST_CAPTURE;
      default:    state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;
    if (flush_i)   state_d = !enable_i ? ST_IDLE : (trig_en_i ? ST_ARMED : ST_CAPTURE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the output is gated by level, which reset clears.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot_we[k]) mem_q[wr_ptr_q + PTR_W'(k)] <= slot_ent[k];
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
module tb_cv32e40p_trace_buffer;
  import cv32e40p_trace_pkg::*;

  localparam int NCH = 2;
  localparam int DEP = 4;

  logic              clk_i = 1'b0;
  logic              rst_i, enable_i, flush_i, trig_en_i;
  logic [31:0]       trig_pc_i;
  logic [NCH-1:0]    ev_valid_i, ev_we_i;
  logic [NCH*32-1:0] ev_pc_i, ev_instr_i, ev_wdata_i;
  logic [NCH*5-1:0]  ev_rd_i;
  logic              rdy0, rdy1, ov0, ov1;
  logic [ENTRY_W-1:0] oe0, oe1;
  logic [2:0]        lvl0, lvl1;
  logic [1:0]        st0, st1;
  logic [2:0]        dc0;
  logic [15:0]       dc1;

  // stop-mode instance with a 3-bit drop counter so saturation is reachable
  cv32e40p_trace_buffer #(.NUM_CH(NCH), .DEPTH(DEP), .WRAP_MODE(0), .DROP_CNT_W(3)) u_stop (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .ev_valid_i(ev_valid_i),
    .ev_pc_i(ev_pc_i), .ev_instr_i(ev_instr_i), .ev_rd_i(ev_rd_i), .ev_we_i(ev_we_i),
    .ev_wdata_i(ev_wdata_i), .out_valid_o(ov0), .out_ready_i(rdy0), .out_entry_o(oe0),
    .level_o(lvl0), .state_o(st0), .drop_cnt_o(dc0));

  cv32e40p_trace_buffer #(.NUM_CH(NCH), .DEPTH(DEP), .WRAP_MODE(1), .DROP_CNT_W(16)) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .ev_valid_i(ev_valid_i),
    .ev_pc_i(ev_pc_i), .ev_instr_i(ev_instr_i), .ev_rd_i(ev_rd_i), .ev_we_i(ev_we_i),
    .ev_wdata_i(ev_wdata_i), .out_valid_o(ov1), .out_ready_i(rdy1), .out_entry_o(oe1),
    .level_o(lvl1), .state_o(st1), .drop_cnt_o(dc1));

  always #5 clk_i = ~clk_i;

  // reference model: one FIFO queue per instance, state as spec numbers
  logic [ENTRY_W-1:0] mq [2][$];
  int m_st [2];
  int m_drop [2];
  int dmax [2] = '{7, 65535};
  int unsigned cyc;
  int n_cmp, n_bad;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry(input int c);
    trace_entry_t t;
    t       = '0;
    t.pc    = ev_pc_i[c*32 +: 32];
    t.instr = ev_instr_i[c*32 +: 32];
    t.we    = ev_we_i[c];
    t.rd    = ev_rd_i[c*5 +: 5];
    t.wdata = ev_wdata_i[c*32 +: 32];
`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    t.ts    = cyc;
`endif
    return t;
  endfunction

  function automatic void bump_drop(input int m);
    if (m_drop[m] < dmax[m]) m_drop[m] = m_drop[m] + 1;
  endfunction

  task automatic model_step(input int m, input logic rdy);
    int start;
    bit hit;
    if (flush_i) begin
      mq[m].delete();
      m_drop[m] = 0;
      m_st[m] = !enable_i ? 0 : (trig_en_i ? 1 : 2);
      return;
    end
    if (rdy && mq[m].size() != 0) void'(mq[m].pop_front());
    start = NCH;
    if (m_st[m] == 2) start = 0;
    else if (m_st[m] == 1)
      for (int c = NCH-1; c >= 0; c--)
        if (ev_valid_i[c] && ev_pc_i[c*32 +: 32] == trig_pc_i) start = c;
    hit = (m_st[m] == 1) && (start < NCH);
    if (m_st[m] == 3)
      for (int c = 0; c < NCH; c++) if (ev_valid_i[c]) bump_drop(m);
    for (int c = start; c < NCH; c++) begin
      if (ev_valid_i[c]) begin
        if (mq[m].size() < DEP) mq[m].push_back(mk_entry(c));
        else if (m == 1) begin
          void'(mq[m].pop_front());
          mq[m].push_back(mk_entry(c));
          bump_drop(m);
        end else bump_drop(m);
      end
    end
    if (!enable_i) m_st[m] = 0;
    else case (m_st[m])
      0: m_st[m] = trig_en_i ? 1 : 2;
      1: m_st[m] = hit ? 2 : 1;
      2: m_st[m] = (m == 0 && mq[m].size() == DEP) ? 3 : 2;
      default: m_st[m] = (mq[m].size() < DEP) ? 2 : 3;
    endcase
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      logic [ENTRY_W-1:0] exp_e;
      exp_e = (mq[m].size() != 0) ? mq[m][0] : '0;
      check($sformatf("d%0d_valid", m), (m == 1) ? ov1 : ov0, mq[m].size() != 0);
      check($sformatf("d%0d_level", m), (m == 1) ? lvl1 : lvl0, mq[m].size());
      check($sformatf("d%0d_state", m), (m == 1) ? st1 : st0, m_st[m]);
      check($sformatf("d%0d_drop", m), (m == 1) ? dc1 : 16'(dc0), m_drop[m]);
      check($sformatf("d%0d_entry", m), (m == 1) ? oe1 : oe0, exp_e);
    end
  endtask

  task automatic tick();
    compare_all();
    model_step(0, rdy0);
    model_step(1, rdy1);
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_st[m] = 0;
      m_drop[m] = 0;
    end
    cyc = 0;
    compare_all();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic set_ev(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    ev_valid_i = v;
    ev_pc_i    = {pc1, pc0};
    for (int c = 0; c < NCH; c++) begin
      ev_instr_i[c*32 +: 32] = $urandom;
      ev_wdata_i[c*32 +: 32] = $urandom;
      ev_rd_i[c*5 +: 5]      = 5'($urandom_range(0, 31));
      ev_we_i[c]             = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_flush(input logic trig);
    set_ev(2'b11, 32'h50, 32'h54);
    trig_en_i = trig;
    flush_i   = 1'b1;
    tick();
    flush_i   = 1'b0;
    set_ev(2'b00, 32'h0, 32'h0);
  endtask

  logic [31:0] ts_a, ts_b;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_i = 1'b1; enable_i = 1'b0; flush_i = 1'b0; trig_en_i = 1'b0; trig_pc_i = '0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    set_ev(2'b00, 32'h0, 32'h0);
    @(negedge clk_i);
    do_reset();

    // stop-on-full: 3 cycles of two events into 4 slots
    enable_i = 1'b1;
    tick();
    set_ev(2'b11, 32'h1000, 32'h1004); tick();
    set_ev(2'b11, 32'h1008, 32'h100C); tick();
    set_ev(2'b11, 32'h1010, 32'h1014); tick();
    set_ev(2'b00, 32'h0, 32'h0);
    check("t1_level", lvl0, 4);
    check("t1_state", st0, 3);
    check("t1_drop", dc0, 2);
    check("t1_head_pc", oe0[31:0], 32'h1000);
    // keep overflowing: 3-bit drop counter must stick at all-ones
    for (int i = 0; i < 3; i++) begin set_ev(2'b11, 32'h2000, 32'h2004); tick(); end
    set_ev(2'b00, 32'h0, 32'h0);
    check("t1_drop_sat", dc0, 7);

    // wrap mode overwrite and drain order
    do_flush(1'b0);
    for (int i = 0; i < 6; i++) begin set_ev(2'b01, 32'h100 + 32'(4*i), 32'h0); tick(); end
    set_ev(2'b00, 32'h0, 32'h0);
    check("t2_level", lvl1, 4);
    check("t2_drop", dc1, 2);
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain%0d", i), oe1[31:0], 32'h108 + 32'(4*i));
      tick();
    end
    rdy1 = 1'b0;
    check("t2_empty", ov1, 1'b0);

    // trigger on channel 1; channel 0 in the same cycle is not captured
    trig_pc_i = 32'h200;
    do_flush(1'b1);
    check("t3_armed", st1, 1);
    set_ev(2'b11, 32'h1FC, 32'h200); tick();
    set_ev(2'b00, 32'h0, 32'h0);
    check("t3_level", lvl1, 1);
    check("t3_state", st1, 2);
    check("t3_head_pc", oe1[31:0], 32'h200);

    // full wrap buffer, pop plus push in the same cycle
    do_flush(1'b0);
    set_ev(2'b11, 32'h400, 32'h404); tick();
    set_ev(2'b11, 32'h408, 32'h40C); tick();
    rdy1 = 1'b1;
    set_ev(2'b01, 32'h300, 32'h0); tick();
    set_ev(2'b00, 32'h0, 32'h0);
    rdy1 = 1'b0;
    check("t4_level", lvl1, 4);
    check("t4_drop", dc1, 0);
    rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t4_tail_pc", oe1[31:0], 32'h300);
    rdy1 = 1'b0;

    // flush overriding same-cycle events, then reset mid-capture
    set_ev(2'b11, 32'h600, 32'h604); tick();
    do_flush(1'b0);
    check("t5_flush_level", lvl0, 0);
    check("t5_flush_valid", ov1, 1'b0);
    check("t5_flush_drop", dc0, 0);
    set_ev(2'b11, 32'h700, 32'h704); tick(); tick();
    do_reset();
    check("t5_rst_level", lvl1, 0);
    check("t5_rst_valid", ov0, 1'b0);
    check("t5_rst_drop", dc1, 0);

`ifdef CV32E40P_TRACE_TIMESTAMP_EN
    enable_i = 1'b1;
    do_flush(1'b0);
    set_ev(2'b01, 32'h800, 32'h0); tick();
    set_ev(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    set_ev(2'b01, 32'h804, 32'h0); tick();
    set_ev(2'b00, 32'h0, 32'h0);
    ts_a = oe1[ENTRY_W-1 -: 32];
    rdy1 = 1'b1; tick(); rdy1 = 1'b0;
    ts_b = oe1[ENTRY_W-1 -: 32];
    check("t6_ts_delta", ts_b - ts_a, 4);
`endif

    // randomized phase against the queue model
    enable_i = 1'b1;
    trig_pc_i = 32'h208;
    for (int i = 0; i < 3000; i++) begin
      enable_i = ($urandom_range(0, 19) != 0);
      flush_i  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) trig_en_i = ~trig_en_i;
      if ($urandom_range(0, 99) == 0) trig_pc_i = 32'h200 + 32'(4*$urandom_range(0, 7));
      rdy0 = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 1) == 1);
      set_ev(2'($urandom_range(0, 3)), 32'h200 + 32'(4*$urandom_range(0, 7)),
             32'h200 + 32'(4*$urandom_range(0, 7)));
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end
    flush_i = 1'b0;
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
